control_sequencer: RTL and testbench

Hardwired control unit that drives the datapath's register-transfer strobes: the PCout/MARin/Read/MDRin/IRin/Yin/ZLowIn/Zlowout control bus and the per-register enables. It fetches an instruction, decodes the IR opcode and register fields, and steps through T0..T6 one state per clock. It replaces hand-sequenced stimulus as the initiator of that control bus, and the datapath is the responder.

---
 rtl/control_sequencer_if.sv | 38 +++
 rtl/control_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer (master) and the datapath (slave):
// instruction/memory status inward, register-transfer strobes outward.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        MemReady;
    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        ZLowIn;
    logic        ZHighIn;
    logic        Zlowout;
    logic        ZHighout;
    logic        LOin;
    logic        HIin;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic [4:0]  alu_op;
    logic        Run;

    modport master (
        input  IR, MemReady,
        output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
               ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin,
               Rout, Rin, alu_op, Run
    );

    modport slave (
        output IR, MemReady,
        input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
               ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin,
               Rout, Rin, alu_op, Run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer, T0..T6 one state per clock.
// Optional feature macro MEM_WAIT_EN: T1 stretches until MemReady is high.
module control_sequencer (
    input  logic                Clock,
    input  logic                Clear,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam int SB_PCOUT    = 13;
    localparam int SB_MARIN    = 12;
    localparam int SB_INCPC    = 11;
    localparam int SB_READ     = 10;
    localparam int SB_MDRIN    = 9;
    localparam int SB_MDROUT   = 8;
    localparam int SB_IRIN     = 7;
    localparam int SB_YIN      = 6;
    localparam int SB_ZLOWIN   = 5;
    localparam int SB_ZHIGHIN  = 4;
    localparam int SB_ZLOWOUT  = 3;
    localparam int SB_ZHIGHOUT = 2;
    localparam int SB_LOIN     = 1;
    localparam int SB_HIIN     = 0;

    localparam logic [4:0] OP_HALT = 5'b11010;

    function automatic logic is_3reg(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd11);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == 5'd15) || (op == 5'd16);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == 5'd17) || (op == 5'd18);
    endfunction

    state_t      r_state;
    logic [13:0] r_strb;
    logic [15:0] r_rout;
    logic [15:0] r_rin;
    logic [4:0]  r_alu_op;
    logic        r_run;

    state_t      w_next_state;
    logic [13:0] w_strb;
    logic [15:0] w_rout;
    logic [15:0] w_rin;
    logic [4:0]  w_alu_op;
    logic        w_run;

    logic [4:0]  w_opcode;
    logic [15:0] w_sel_ra;
    logic [15:0] w_sel_rb;
    logic [15:0] w_sel_rc;
    logic        w_unused_ir;

    assign w_opcode    = bus.IR[31:27];
    assign w_sel_ra    = 16'd1 << bus.IR[26:23];
    assign w_sel_rb    = 16'd1 << bus.IR[22:19];
    assign w_sel_rc    = 16'd1 << bus.IR[18:15];
    assign w_unused_ir = ^{bus.IR[14:0], bus.MemReady};

    // Next-state sequencing, including the opcode branch out of T2.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RST: w_next_state = S_T0;
            S_T0:  w_next_state = S_T1;
`ifdef MEM_WAIT_EN
            S_T1:  w_next_state = bus.MemReady ? S_T2 : S_T1;
`else
            S_T1:  w_next_state = S_T2;
`endif
            S_T2: begin
                if (is_3reg(w_opcode) || is_muldiv(w_opcode) || is_unary(w_opcode)) begin
                    w_next_state = S_T3;
                end else if (w_opcode == OP_HALT) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_T0;
                end
            end
            S_T3:   w_next_state = S_T4;
            S_T4:   w_next_state = S_T5;
            S_T5:   w_next_state = is_muldiv(w_opcode) ? S_T6 : S_T0;
            S_T6:   w_next_state = S_T0;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_RST;
        endcase
    end

    // Strobe decode for the state being entered, so outputs are registered Moore values.
    always_comb begin
        w_strb   = 14'd0;
        w_rout   = 16'd0;
        w_rin    = 16'd0;
        w_alu_op = 5'd0;
        w_run    = 1'b0;
        case (w_next_state)
            S_T0: begin
                w_run              = 1'b1;
                w_strb[SB_PCOUT]   = 1'b1;
                w_strb[SB_MARIN]   = 1'b1;
                w_strb[SB_INCPC]   = 1'b1;
            end
            S_T1: begin
                w_run              = 1'b1;
                w_strb[SB_READ]    = 1'b1;
                w_strb[SB_MDRIN]   = 1'b1;
            end
            S_T2: begin
                w_run              = 1'b1;
                w_strb[SB_MDROUT]  = 1'b1;
                w_strb[SB_IRIN]    = 1'b1;
            end
            S_T3: begin
                w_run = 1'b1;
                if (is_3reg(w_opcode)) begin
                    w_rout         = w_sel_rb;
                    w_strb[SB_YIN] = 1'b1;
                end else if (is_muldiv(w_opcode)) begin
                    w_rout         = w_sel_ra;
                    w_strb[SB_YIN] = 1'b1;
                end else begin
                    w_rout         = 16'd0;
                end
            end
            S_T4: begin
                w_run = 1'b1;
                // Operand order differs per class: 3-reg reads Rc, unary and mul/div read Rb.
                if (is_3reg(w_opcode)) begin
                    w_rout             = w_sel_rc;
                    w_alu_op           = w_opcode;
                    w_strb[SB_ZLOWIN]  = 1'b1;
                end else if (is_unary(w_opcode)) begin
                    w_rout             = w_sel_rb;
                    w_alu_op           = w_opcode;
                    w_strb[SB_ZLOWIN]  = 1'b1;
                end else if (is_muldiv(w_opcode)) begin
                    w_rout             = w_sel_rb;
                    w_alu_op           = w_opcode;
                    w_strb[SB_ZLOWIN]  = 1'b1;
                    w_strb[SB_ZHIGHIN] = 1'b1;
                end else begin
                    w_rout             = 16'd0;
                end
            end
            S_T5: begin
                w_run              = 1'b1;
                w_strb[SB_ZLOWOUT] = 1'b1;
                if (is_muldiv(w_opcode)) begin
                    w_strb[SB_LOIN] = 1'b1;
                end else begin
                    w_rin           = w_sel_ra;
                end
            end
            S_T6: begin
                w_run               = 1'b1;
                w_strb[SB_ZHIGHOUT] = 1'b1;
                w_strb[SB_HIIN]     = 1'b1;
            end
            default: w_run = 1'b0;
        endcase
    end

    // State and output registers; Clear drops every strobe asynchronously.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state  <= S_RST;
            r_strb   <= 14'd0;
            r_rout   <= 16'd0;
            r_rin    <= 16'd0;
            r_alu_op <= 5'd0;
            r_run    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_strb   <= w_strb;
            r_rout   <= w_rout;
            r_rin    <= w_rin;
            r_alu_op <= w_alu_op;
            r_run    <= w_run;
        end
    end

    assign bus.PCout    = r_strb[SB_PCOUT];
    assign bus.MARin    = r_strb[SB_MARIN];
    assign bus.IncPC    = r_strb[SB_INCPC];
    assign bus.Read     = r_strb[SB_READ];
    assign bus.MDRin    = r_strb[SB_MDRIN];
    assign bus.MDRout   = r_strb[SB_MDROUT];
    assign bus.IRin     = r_strb[SB_IRIN];
    assign bus.Yin      = r_strb[SB_YIN];
    assign bus.ZLowIn   = r_strb[SB_ZLOWIN];
    assign bus.ZHighIn  = r_strb[SB_ZHIGHIN];
    assign bus.Zlowout  = r_strb[SB_ZLOWOUT];
    assign bus.ZHighout = r_strb[SB_ZHIGHOUT];
    assign bus.LOin     = r_strb[SB_LOIN];
    assign bus.HIin     = r_strb[SB_HIIN];
    assign bus.Rout     = r_rout;
    assign bus.Rin      = r_rin;
    assign bus.alu_op   = r_alu_op;
    assign bus.Run      = r_run;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against a per-instruction
// cycle-list model built from the instruction-class timing rules.
module tb_control_sequencer;

    typedef struct packed {
        logic [13:0] strb;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  alu;
        logic        run;
    } outs_t;

    localparam logic [13:0] PCOUT    = 14'd1 << 13;
    localparam logic [13:0] MARIN    = 14'd1 << 12;
    localparam logic [13:0] INCPC    = 14'd1 << 11;
    localparam logic [13:0] READ     = 14'd1 << 10;
    localparam logic [13:0] MDRIN    = 14'd1 << 9;
    localparam logic [13:0] MDROUT   = 14'd1 << 8;
    localparam logic [13:0] IRIN     = 14'd1 << 7;
    localparam logic [13:0] YIN      = 14'd1 << 6;
    localparam logic [13:0] ZLOWIN   = 14'd1 << 5;
    localparam logic [13:0] ZHIGHIN  = 14'd1 << 4;
    localparam logic [13:0] ZLOWOUT  = 14'd1 << 3;
    localparam logic [13:0] ZHIGHOUT = 14'd1 << 2;
    localparam logic [13:0] LOIN     = 14'd1 << 1;
    localparam logic [13:0] HIIN     = 14'd1 << 0;

`ifdef MEM_WAIT_EN
    localparam bit MW = 1'b1;
`else
    localparam bit MW = 1'b0;
`endif

    logic        Clock;
    logic        Clear;
    logic [31:0] cur_ir;
    int          n_cmp;
    int          n_fail;
    outs_t       exp_q[$];
    outs_t       obs;

    control_sequencer_if bus_if ();

    control_sequencer dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus_if.master)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic outs_t observe();
        outs_t o;
        o.strb = {bus_if.PCout, bus_if.MARin, bus_if.IncPC, bus_if.Read, bus_if.MDRin,
                  bus_if.MDRout, bus_if.IRin, bus_if.Yin, bus_if.ZLowIn, bus_if.ZHighIn,
                  bus_if.Zlowout, bus_if.ZHighout, bus_if.LOin, bus_if.HIin};
        o.rout = bus_if.Rout;
        o.rin  = bus_if.Rin;
        o.alu  = bus_if.alu_op;
        o.run  = bus_if.Run;
        return o;
    endfunction

    function automatic outs_t mk(input logic [13:0] s, input logic [15:0] ro,
                                 input logic [15:0] ri, input logic [4:0] alu);
        outs_t o;
        o.strb = s;
        o.rout = ro;
        o.rin  = ri;
        o.alu  = alu;
        o.run  = 1'b1;
        return o;
    endfunction

    // Expected outputs for each clock of one instruction, starting at T0.
    function automatic void build(input logic [31:0] ir, input int waits);
        logic [4:0]  op;
        logic [15:0] one;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rc;
        int          nread;
        op  = ir[31:27];
        one = 16'd1;
        ra  = one << ir[26:23];
        rb  = one << ir[22:19];
        rc  = one << ir[18:15];
        nread = MW ? waits + 1 : 1;
        exp_q.delete();
        exp_q.push_back(mk(PCOUT | MARIN | INCPC, 16'd0, 16'd0, 5'd0));
        for (int w = 0; w < nread; w++) exp_q.push_back(mk(READ | MDRIN, 16'd0, 16'd0, 5'd0));
        exp_q.push_back(mk(MDROUT | IRIN, 16'd0, 16'd0, 5'd0));
        if (op >= 5'd3 && op <= 5'd11) begin
            exp_q.push_back(mk(YIN, rb, 16'd0, 5'd0));
            exp_q.push_back(mk(ZLOWIN, rc, 16'd0, op));
            exp_q.push_back(mk(ZLOWOUT, 16'd0, ra, 5'd0));
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(mk(YIN, ra, 16'd0, 5'd0));
            exp_q.push_back(mk(ZLOWIN | ZHIGHIN, rb, 16'd0, op));
            exp_q.push_back(mk(ZLOWOUT | LOIN, 16'd0, 16'd0, 5'd0));
            exp_q.push_back(mk(ZHIGHOUT | HIIN, 16'd0, 16'd0, 5'd0));
        end else if (op == 5'd17 || op == 5'd18) begin
            exp_q.push_back(mk(14'd0, 16'd0, 16'd0, 5'd0));
            exp_q.push_back(mk(ZLOWIN, rb, 16'd0, op));
            exp_q.push_back(mk(ZLOWOUT, 16'd0, ra, 5'd0));
        end
    endfunction

    // One clock: sample point #1 after posedge, then set up inputs for the next edge.
    task automatic tick(input int j, input int waits);
        @(posedge Clock);
        #1;
        if (j >= 1 && j <= waits) bus_if.MemReady = 1'b0;
        else if (j == waits + 1)  bus_if.MemReady = 1'b1;
        else                      bus_if.MemReady = 1'($urandom_range(0, 1));
        if (j == 0) bus_if.IR = cur_ir;
        obs = observe();
    endtask

    task automatic test_reset();
        Clear = 1'b1;
        bus_if.IR = 32'd0;
        bus_if.MemReady = 1'b1;
        #1;
        obs = observe();
        n_cmp++;
        if (obs !== outs_t'(0)) begin
            $display("FAIL reset_async got=%h exp=0", obs);
            n_fail++;
        end
        repeat (2) @(posedge Clock);
        #1;
        obs = observe();
        n_cmp++;
        if (obs !== outs_t'(0)) begin
            $display("FAIL reset_held got=%h exp=0", obs);
            n_fail++;
        end
        @(negedge Clock);
        Clear = 1'b0;
    endtask

    task automatic test_and_example();
        cur_ir = 32'h28918000;
        build(cur_ir, 0);
        for (int j = 0; j < exp_q.size(); j++) begin
            tick(j, 0);
            n_cmp++;
            if (obs !== exp_q[j]) begin
                $display("FAIL and_seq cyc=%0d got=%h exp=%h", j, obs, exp_q[j]);
                n_fail++;
            end
        end
        n_cmp++;
        if (exp_q.size() != 6) begin
            $display("FAIL and_len got=%0d exp=6", exp_q.size());
            n_fail++;
        end
    endtask

    task automatic test_mem_wait();
        int reads;
        int exp_reads;
        reads = 0;
        exp_reads = MW ? 4 : 1;
        cur_ir = 32'h18918000;
        build(cur_ir, 3);
        for (int j = 0; j < exp_q.size(); j++) begin
            tick(j, 3);
            if (bus_if.Read === 1'b1 && bus_if.MDRin === 1'b1) reads++;
            n_cmp++;
            if (obs !== exp_q[j]) begin
                $display("FAIL memwait_seq cyc=%0d got=%h exp=%h", j, obs, exp_q[j]);
                n_fail++;
            end
        end
        n_cmp++;
        if (reads != exp_reads) begin
            $display("FAIL memwait_reads got=%0d exp=%0d", reads, exp_reads);
            n_fail++;
        end
    endtask

    task automatic test_mul();
        int rin_seen;
        rin_seen = 0;
        cur_ir = 32'h7A280000;
        build(cur_ir, 0);
        for (int j = 0; j < exp_q.size(); j++) begin
            tick(j, 0);
            if (bus_if.Rin !== 16'd0) rin_seen++;
            n_cmp++;
            if (obs !== exp_q[j]) begin
                $display("FAIL mul_seq cyc=%0d got=%h exp=%h", j, obs, exp_q[j]);
                n_fail++;
            end
        end
        n_cmp++;
        if (rin_seen != 0) begin
            $display("FAIL mul_rin got=%0d exp=0", rin_seen);
            n_fail++;
        end
    endtask

    task automatic test_undefined_and_nop();
        logic [31:0] irs [2];
        irs[0] = 32'hF8000000;
        irs[1] = 32'hC8000000;
        for (int k = 0; k < 2; k++) begin
            cur_ir = irs[k];
            build(cur_ir, 0);
            for (int j = 0; j < exp_q.size(); j++) begin
                tick(j, 0);
                n_cmp++;
                if (obs !== exp_q[j]) begin
                    $display("FAIL undef_seq ir=%h cyc=%0d got=%h exp=%h", cur_ir, j, obs, exp_q[j]);
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_random();
        int waits;
        logic [4:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11010) op = 5'b11001;
            cur_ir = {op, 27'($urandom)};
            waits = $urandom_range(0, 3);
            build(cur_ir, waits);
            for (int j = 0; j < exp_q.size(); j++) begin
                tick(j, waits);
                n_cmp++;
                if (obs !== exp_q[j]) begin
                    $display("FAIL random ir=%h w=%0d cyc=%0d got=%h exp=%h", cur_ir, waits, j, obs, exp_q[j]);
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_clear_mid();
        cur_ir = 32'h19A38000;
        build(cur_ir, 0);
        for (int j = 0; j < 5; j++) begin
            tick(j, 0);
            n_cmp++;
            if (obs !== exp_q[j]) begin
                $display("FAIL clrmid_pre cyc=%0d got=%h exp=%h", j, obs, exp_q[j]);
                n_fail++;
            end
        end
        #2;
        Clear = 1'b1;
        #1;
        obs = observe();
        n_cmp++;
        if (obs !== outs_t'(0)) begin
            $display("FAIL clrmid_drop got=%h exp=0", obs);
            n_fail++;
        end
        @(posedge Clock);
        #1;
        obs = observe();
        n_cmp++;
        if (obs !== outs_t'(0)) begin
            $display("FAIL clrmid_norin got=%h exp=0", obs);
            n_fail++;
        end
        @(negedge Clock);
        Clear = 1'b0;
        cur_ir = 32'h8A000000;
        build(cur_ir, 0);
        for (int j = 0; j < exp_q.size(); j++) begin
            tick(j, 0);
            n_cmp++;
            if (obs !== exp_q[j]) begin
                $display("FAIL clrmid_post cyc=%0d got=%h exp=%h", j, obs, exp_q[j]);
                n_fail++;
            end
        end
    endtask

    task automatic test_halt();
        int bad;
        bad = 0;
        cur_ir = 32'hD0000000;
        build(cur_ir, 0);
        for (int j = 0; j < exp_q.size(); j++) begin
            tick(j, 0);
            n_cmp++;
            if (obs !== exp_q[j]) begin
                $display("FAIL halt_fetch cyc=%0d got=%h exp=%h", j, obs, exp_q[j]);
                n_fail++;
            end
        end
        for (int k = 0; k < 22; k++) begin
            tick(100 + k, 0);
            if (obs !== outs_t'(0)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            $display("FAIL halt_hold got=%0d nonzero cycles exp=0", bad);
            n_fail++;
        end
        #2;
        Clear = 1'b1;
        #1;
        obs = observe();
        n_cmp++;
        if (obs !== outs_t'(0)) begin
            $display("FAIL halt_clear got=%h exp=0", obs);
            n_fail++;
        end
        @(negedge Clock);
        Clear = 1'b0;
        cur_ir = 32'hC8000000;
        build(cur_ir, 0);
        for (int j = 0; j < exp_q.size(); j++) begin
            tick(j, 0);
            n_cmp++;
            if (obs !== exp_q[j]) begin
                $display("FAIL halt_restart cyc=%0d got=%h exp=%h", j, obs, exp_q[j]);
                n_fail++;
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cur_ir = 32'd0;
        test_reset();
        test_and_example();
        test_mem_wait();
        test_mul();
        test_undefined_and_nop();
        test_random();
        test_clear_mid();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
